embedded_io_ctrl: RTL and testbench

- Core-side controller that sits directly upstream of the isolating embedded I/O cell.
- Drives the cell's IO_ISOL_N, FPGA_OUT and FPGA_DIR inputs.
- Consumes the cell's FPGA_IN outputs, synchronising them and detecting rising edges.
- Holds all I/Os isolated until configuration completes and a settle delay has elapsed, then runs; returns to isolation through a drain phase.

---
 rtl/embedded_io_pkg.sv | 22 ++
 rtl/embedded_io_ctrl_sync.sv | 31 +++
 rtl/embedded_io_ctrl.sv | 121 ++++++++++++
 tb/tb_embedded_io_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/embedded_io_pkg.sv
// Shared types and helpers for the embedded I/O controller.
package embedded_io_pkg;

    // Controller states; encodings are visible on the STATE output.
    typedef enum logic [1:0] {
        ISOL   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } io_state_t;

    // Width of the shared settle/drain down-counter: enough to hold the
    // larger of the two delays minus one, never narrower than one bit.
    function automatic int cnt_width(input int releaseDly, input int drainDly);
        int maxDly;
        int w;
        maxDly = (releaseDly > drainDly) ? releaseDly : drainDly;
        w      = $clog2(maxDly);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/embedded_io_ctrl_sync.sv
// One inbound I/O bit: multi-flop synchroniser plus rising-edge detect.
module io_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic raw_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    // Shift the asynchronous input through the chain and remember the last
    // stage's previous value so a 0->1 transition can be spotted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], raw_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = en_i & sync_o & ~prev_q;

endmodule

// File: rtl/embedded_io_ctrl.sv
// Core-side controller for the isolating embedded I/O cell: sequences
// isolation release/re-assertion and synchronises the inbound data.
module embedded_io_ctrl
    import embedded_io_pkg::*;
#(
    parameter int NUM_IO      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RELEASE_DLY = 16,
    parameter int DRAIN_DLY   = 2
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              CONFIG_DONE,
    input  logic              ISOL_REQ,
    input  logic [NUM_IO-1:0] FPGA_OUT_CORE,
    input  logic [NUM_IO-1:0] FPGA_DIR_CORE,
    input  logic [NUM_IO-1:0] FPGA_IN_RAW,
    output logic              IO_ISOL_N,
    output logic [NUM_IO-1:0] FPGA_OUT,
    output logic [NUM_IO-1:0] FPGA_DIR,
    output logic [NUM_IO-1:0] FPGA_IN_SYNC,
    output logic [NUM_IO-1:0] FPGA_IN_RISE,
    output logic [1:0]        STATE
);

    localparam int               CNT_W       = cnt_width(RELEASE_DLY, DRAIN_DLY);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(RELEASE_DLY - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_DLY - 1);

    io_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              isolN_q;
    logic [NUM_IO-1:0] out_q;
    logic [NUM_IO-1:0] dir_q;
    logic              riseEn_q;
    logic              leaveReq;

    assign leaveReq = !CONFIG_DONE || ISOL_REQ;

    // Next-state and counter decode; DRAIN deliberately ignores the inputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ISOL: begin
                if (CONFIG_DONE && !ISOL_REQ) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (leaveReq) begin
                    state_d = ISOL;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (leaveReq) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ISOL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ISOL;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and every cell-facing output are registered from the
    // next state, so isolation and data change on the same edge as the FSM.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= ISOL;
            cnt_q    <= '0;
            isolN_q  <= 1'b0;
            out_q    <= '0;
            dir_q    <= '0;
            riseEn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            isolN_q  <= (state_d == RUN) || (state_d == DRAIN);
            out_q    <= (state_d == RUN) ? FPGA_OUT_CORE : '0;
            dir_q    <= (state_d == RUN) ? FPGA_DIR_CORE : '0;
            riseEn_q <= (state_q == RUN) && (state_d == RUN);
        end
    end

    // Edge pulses are only allowed once RUN has been held for a full cycle,
    // so an edge landing on the RUN-entry edge is suppressed.
    for (genvar g = 0; g < NUM_IO; g++) begin : g_sync
        io_sync_bit #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (CK),
            .rst_i (RST),
            .en_i  (riseEn_q),
            .raw_i (FPGA_IN_RAW[g]),
            .sync_o(FPGA_IN_SYNC[g]),
            .rise_o(FPGA_IN_RISE[g])
        );
    end

    assign IO_ISOL_N = isolN_q;
    assign FPGA_OUT  = out_q;
    assign FPGA_DIR  = dir_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_embedded_io_ctrl.sv
// Self-checking bench for embedded_io_ctrl using a per-cycle scoreboard.
module tb_embedded_io_ctrl;

    localparam int NUM_IO      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int RELEASE_DLY = 16;
    localparam int DRAIN_DLY   = 2;

    localparam logic [1:0] S_ISOL   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic              CK = 1'b0;
    logic              RST = 1'b1;
    logic              CONFIG_DONE = 1'b0;
    logic              ISOL_REQ = 1'b0;
    logic [NUM_IO-1:0] FPGA_OUT_CORE = '0;
    logic [NUM_IO-1:0] FPGA_DIR_CORE = '0;
    logic [NUM_IO-1:0] FPGA_IN_RAW = '0;
    logic              IO_ISOL_N;
    logic [NUM_IO-1:0] FPGA_OUT;
    logic [NUM_IO-1:0] FPGA_DIR;
    logic [NUM_IO-1:0] FPGA_IN_SYNC;
    logic [NUM_IO-1:0] FPGA_IN_RISE;
    logic [1:0]        STATE;

    int checksRun    = 0;
    int checksPassed = 0;

    // One scoreboard entry: the stimulus for a cycle and what must be
    // visible just after that cycle's rising edge.
    typedef struct {
        string      tag;
        logic       rst;
        logic       cd;
        logic       ir;
        logic [7:0] oc;
        logic [7:0] dc;
        logic [7:0] raw;
        logic [1:0] st;
        logic       isoln;
        logic [7:0] out;
        logic [7:0] dir;
        logic [7:0] sync;
        logic [7:0] rise;
    } item_t;

    item_t sbQ[$];

    embedded_io_ctrl #(
        .NUM_IO     (NUM_IO),
        .SYNC_STAGES(SYNC_STAGES),
        .RELEASE_DLY(RELEASE_DLY),
        .DRAIN_DLY  (DRAIN_DLY)
    ) dut (
        .CK           (CK),
        .RST          (RST),
        .CONFIG_DONE  (CONFIG_DONE),
        .ISOL_REQ     (ISOL_REQ),
        .FPGA_OUT_CORE(FPGA_OUT_CORE),
        .FPGA_DIR_CORE(FPGA_DIR_CORE),
        .FPGA_IN_RAW  (FPGA_IN_RAW),
        .IO_ISOL_N    (IO_ISOL_N),
        .FPGA_OUT     (FPGA_OUT),
        .FPGA_DIR     (FPGA_DIR),
        .FPGA_IN_SYNC (FPGA_IN_SYNC),
        .FPGA_IN_RISE (FPGA_IN_RISE),
        .STATE        (STATE)
    );

    // Free-running clock.
    always #5 CK = ~CK;

    // Queue a cycle of stimulus with its expected outcome.
    task automatic sched(input string tag, input logic rst, input logic cd, input logic ir,
                         input logic [7:0] oc, input logic [7:0] dc, input logic [7:0] raw,
                         input logic [1:0] st, input logic isoln, input logic [7:0] out,
                         input logic [7:0] dir, input logic [7:0] sync, input logic [7:0] rise);
        item_t it;
        it.tag = tag; it.rst = rst; it.cd = cd; it.ir = ir;
        it.oc = oc; it.dc = dc; it.raw = raw;
        it.st = st; it.isoln = isoln; it.out = out; it.dir = dir;
        it.sync = sync; it.rise = rise;
        sbQ.push_back(it);
    endtask

    // Drive the head entry's inputs on the falling edge.
    task automatic applyStimulus();
        @(negedge CK);
        RST           = sbQ[0].rst;
        CONFIG_DONE   = sbQ[0].cd;
        ISOL_REQ      = sbQ[0].ir;
        FPGA_OUT_CORE = sbQ[0].oc;
        FPGA_DIR_CORE = sbQ[0].dc;
        FPGA_IN_RAW   = sbQ[0].raw;
        @(posedge CK);
        #1;
    endtask

    // Reset holds everything at zero even with busy inputs, then idles.
    task automatic test_reset();
        item_t e;
        for (int i = 0; i < 3; i++)
            sched("reset", 1, 0, 0, 8'hFF, 8'hFF, 8'hFF, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("reset_idle", 0, 0, 0, 8'hFF, 8'hFF, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        while (sbQ.size() != 0) begin
            applyStimulus();
            e = sbQ.pop_front();
            checksRun++;
            if ({STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE} !==
                {e.st, e.isoln, e.out, e.dir, e.sync, e.rise})
                $display("[TB] FAIL %s: got st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h, want st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h",
                         e.tag, STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE,
                         e.st, e.isoln, e.out, e.dir, e.sync, e.rise);
            else
                checksPassed++;
        end
    endtask

    // Both requests high holds ISOL; then a full settle into RUN.
    task automatic test_release();
        item_t e;
        sched("both_high", 0, 1, 1, 8'hA5, 8'h0F, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < RELEASE_DLY; i++)
            sched("settle", 0, 1, 0, 8'hA5, 8'h0F, 8'h00, S_SETTLE, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("run_entry", 0, 1, 0, 8'hA5, 8'h0F, 8'h00, S_RUN, 1, 8'hA5, 8'h0F, 8'h00, 8'h00);
        while (sbQ.size() != 0) begin
            applyStimulus();
            e = sbQ.pop_front();
            checksRun++;
            if ({STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE} !==
                {e.st, e.isoln, e.out, e.dir, e.sync, e.rise})
                $display("[TB] FAIL %s: got st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h, want st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h",
                         e.tag, STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE,
                         e.st, e.isoln, e.out, e.dir, e.sync, e.rise);
            else
                checksPassed++;
        end
    endtask

    // Outbound data and direction follow the core with one cycle latency.
    task automatic test_output();
        item_t e;
        logic [7:0] ro, rd;
        sched("out_3c", 0, 1, 0, 8'h3C, 8'hF0, 8'h00, S_RUN, 1, 8'h3C, 8'hF0, 8'h00, 8'h00);
        sched("out_00", 0, 1, 0, 8'h00, 8'hFF, 8'h00, S_RUN, 1, 8'h00, 8'hFF, 8'h00, 8'h00);
        sched("out_ff", 0, 1, 0, 8'hFF, 8'h00, 8'h00, S_RUN, 1, 8'hFF, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            ro = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            sched("out_rand", 0, 1, 0, ro, rd, 8'h00, S_RUN, 1, ro, rd, 8'h00, 8'h00);
        end
        while (sbQ.size() != 0) begin
            applyStimulus();
            e = sbQ.pop_front();
            checksRun++;
            if ({STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE} !==
                {e.st, e.isoln, e.out, e.dir, e.sync, e.rise})
                $display("[TB] FAIL %s: got st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h, want st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h",
                         e.tag, STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE,
                         e.st, e.isoln, e.out, e.dir, e.sync, e.rise);
            else
                checksPassed++;
        end
    endtask

    // Inbound edges in RUN: two-cycle sync latency and a single-cycle pulse.
    task automatic test_inbound_run();
        item_t e;
        sched("in_b3_s1", 0, 1, 0, 8'h5A, 8'hAA, 8'h08, S_RUN, 1, 8'h5A, 8'hAA, 8'h00, 8'h00);
        sched("in_b3_s2", 0, 1, 0, 8'h5A, 8'hAA, 8'h08, S_RUN, 1, 8'h5A, 8'hAA, 8'h08, 8'h08);
        sched("in_b3_hold", 0, 1, 0, 8'h5A, 8'hAA, 8'h08, S_RUN, 1, 8'h5A, 8'hAA, 8'h08, 8'h00);
        sched("in_f9_s1", 0, 1, 0, 8'h5A, 8'hAA, 8'hF9, S_RUN, 1, 8'h5A, 8'hAA, 8'h08, 8'h00);
        sched("in_f9_s2", 0, 1, 0, 8'h5A, 8'hAA, 8'hF9, S_RUN, 1, 8'h5A, 8'hAA, 8'hF9, 8'hF1);
        sched("in_zero_s1", 0, 1, 0, 8'h5A, 8'hAA, 8'h00, S_RUN, 1, 8'h5A, 8'hAA, 8'hF9, 8'h00);
        sched("in_zero_s2", 0, 1, 0, 8'h5A, 8'hAA, 8'h00, S_RUN, 1, 8'h5A, 8'hAA, 8'h00, 8'h00);
        while (sbQ.size() != 0) begin
            applyStimulus();
            e = sbQ.pop_front();
            checksRun++;
            if ({STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE} !==
                {e.st, e.isoln, e.out, e.dir, e.sync, e.rise})
                $display("[TB] FAIL %s: got st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h, want st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h",
                         e.tag, STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE,
                         e.st, e.isoln, e.out, e.dir, e.sync, e.rise);
            else
                checksPassed++;
        end
    endtask

    // One-cycle isolation request in RUN: full drain with outputs low, then ISOL.
    task automatic test_drain();
        item_t e;
        sched("drain_1", 0, 1, 1, 8'h77, 8'hFF, 8'h00, S_DRAIN, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("drain_2", 0, 1, 0, 8'h77, 8'hFF, 8'h00, S_DRAIN, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("drain_isol", 0, 1, 0, 8'h77, 8'hFF, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("drain_idle", 0, 0, 0, 8'h77, 8'hFF, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        while (sbQ.size() != 0) begin
            applyStimulus();
            e = sbQ.pop_front();
            checksRun++;
            if ({STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE} !==
                {e.st, e.isoln, e.out, e.dir, e.sync, e.rise})
                $display("[TB] FAIL %s: got st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h, want st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h",
                         e.tag, STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE,
                         e.st, e.isoln, e.out, e.dir, e.sync, e.rise);
            else
                checksPassed++;
        end
    endtask

    // Inbound edge while isolated: sync still tracks, no pulse.
    task automatic test_inbound_isol();
        item_t e;
        sched("isol_in_s1", 0, 0, 0, 8'h00, 8'h00, 8'h08, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("isol_in_s2", 0, 0, 0, 8'h00, 8'h00, 8'h08, S_ISOL, 0, 8'h00, 8'h00, 8'h08, 8'h00);
        sched("isol_in_z1", 0, 0, 0, 8'h00, 8'h00, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h08, 8'h00);
        sched("isol_in_z2", 0, 0, 0, 8'h00, 8'h00, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        while (sbQ.size() != 0) begin
            applyStimulus();
            e = sbQ.pop_front();
            checksRun++;
            if ({STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE} !==
                {e.st, e.isoln, e.out, e.dir, e.sync, e.rise})
                $display("[TB] FAIL %s: got st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h, want st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h",
                         e.tag, STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE,
                         e.st, e.isoln, e.out, e.dir, e.sync, e.rise);
            else
                checksPassed++;
        end
    endtask

    // Abort SETTLE after 7 cycles, then a complete fresh settle; an inbound
    // edge landing on the RUN-entry edge must not pulse.
    task automatic test_abort();
        item_t e;
        for (int i = 0; i < 7; i++)
            sched("abort_settle", 0, 1, 0, 8'hC3, 8'h3C, 8'h00, S_SETTLE, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("abort_isol", 0, 1, 1, 8'hC3, 8'h3C, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < RELEASE_DLY - 1; i++)
            sched("resettle", 0, 1, 0, 8'hC3, 8'h3C, 8'h00, S_SETTLE, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("resettle_last", 0, 1, 0, 8'hC3, 8'h3C, 8'h08, S_SETTLE, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("run_entry_edge", 0, 1, 0, 8'hC3, 8'h3C, 8'h08, S_RUN, 1, 8'hC3, 8'h3C, 8'h08, 8'h00);
        sched("run_after_edge", 0, 1, 0, 8'hC3, 8'h3C, 8'h08, S_RUN, 1, 8'hC3, 8'h3C, 8'h08, 8'h00);
        while (sbQ.size() != 0) begin
            applyStimulus();
            e = sbQ.pop_front();
            checksRun++;
            if ({STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE} !==
                {e.st, e.isoln, e.out, e.dir, e.sync, e.rise})
                $display("[TB] FAIL %s: got st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h, want st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h",
                         e.tag, STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE,
                         e.st, e.isoln, e.out, e.dir, e.sync, e.rise);
            else
                checksPassed++;
        end
    endtask

    // Reset mid-RUN goes straight to ISOL with no drain and clears the sync chain.
    task automatic test_reset_mid_run();
        item_t e;
        sched("pre_rst_s1", 0, 1, 0, 8'hFF, 8'hFF, 8'h81, S_RUN, 1, 8'hFF, 8'hFF, 8'h08, 8'h00);
        sched("pre_rst_s2", 0, 1, 0, 8'hFF, 8'hFF, 8'h81, S_RUN, 1, 8'hFF, 8'hFF, 8'h81, 8'h81);
        sched("mid_rst", 1, 1, 0, 8'hFF, 8'hFF, 8'h81, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("post_rst_s1", 0, 0, 0, 8'hFF, 8'hFF, 8'h81, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        sched("post_rst_s2", 0, 0, 0, 8'hFF, 8'hFF, 8'h81, S_ISOL, 0, 8'h00, 8'h00, 8'h81, 8'h00);
        sched("post_rst_z1", 0, 0, 0, 8'hFF, 8'hFF, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h81, 8'h00);
        sched("post_rst_z2", 0, 0, 0, 8'hFF, 8'hFF, 8'h00, S_ISOL, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        while (sbQ.size() != 0) begin
            applyStimulus();
            e = sbQ.pop_front();
            checksRun++;
            if ({STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE} !==
                {e.st, e.isoln, e.out, e.dir, e.sync, e.rise})
                $display("[TB] FAIL %s: got st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h, want st=%0d isoln=%b out=%h dir=%h sync=%h rise=%h",
                         e.tag, STATE, IO_ISOL_N, FPGA_OUT, FPGA_DIR, FPGA_IN_SYNC, FPGA_IN_RISE,
                         e.st, e.isoln, e.out, e.dir, e.sync, e.rise);
            else
                checksPassed++;
        end
    endtask

    // Scenario sequence; each scenario leaves the DUT in the state the next expects.
    initial begin
        test_reset();
        test_release();
        test_output();
        test_inbound_run();
        test_drain();
        test_inbound_isol();
        test_abort();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
